// File: rtl/cbb_ecc_enc_pipe.sv
// Multi-lane pipelined SECDED encoder with valid/ready flow control.
// Define CBB_ECC_INJ_EN to include the one-shot error-injection logic.
module cbb_ecc_enc_pipe #(
    parameter int DW     = 64,
    parameter int EW     = 8,
    parameter int LANES  = 2,
    parameter int STAGES = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [LANES*DW-1:0]                           s_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [LANES*(DW+EW)-1:0]                      m_data,
    input  logic                                          inj_arm,
    input  logic [1:0]                                    inj_mode,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] inj_lane,
    input  logic [$clog2(DW+EW)-1:0]                      inj_pos,
    output logic                                          inj_busy,
    output logic                                          inj_done,
    output logic [15:0]                                   inj_cnt
);

    localparam int CW = DW + EW;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = $clog2(CW);

    // Hamming position of data bit idx: idx-th non-power-of-two in 1..CW-1.
    function automatic int data_pos(input int idx);
        int cnt;
        int p;
        cnt = 0;
        p   = 0;
        for (int q = 1; q < CW; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == idx) p = q;
                cnt++;
            end
        end
        return p;
    endfunction

    logic [LANES*CW-1:0] enc_data;
    logic [LANES*CW-1:0] stage_in;

    always_comb begin
        logic [DW-1:0] d;
        logic [EW-1:0] e;
        int            p;
        enc_data = '0;
        d        = '0;
        e        = '0;
        p        = 0;
        for (int k = 0; k < LANES; k++) begin
            d = s_data[k*DW +: DW];
            e = '0;
            for (int i = 0; i < DW; i++) begin
                p = data_pos(i);
                for (int g = 0; g < EW - 1; g++) begin
                    if (p[g]) e[g] = e[g] ^ d[i];
                end
            end
            e[EW-1] = (^d) ^ (^e[EW-2:0]);
            enc_data[k*CW +: CW] = {e, d};
        end
    end

`ifdef CBB_ECC_INJ_EN
    logic          busy_q;
    logic          dbl_q;
    logic [LW-1:0] lane_q;
    logic [PW-1:0] pos_q;
    logic          done_q;
    logic [15:0]   cnt_q;
    logic          accept;
    logic          apply;
    logic          arm_ok;
    logic [CW-1:0] flip;

    assign accept = s_valid & s_ready;
    // busy_q is registered, so a beat accepted in the arm cycle itself is never hit
    assign apply  = accept & busy_q;
    assign arm_ok = inj_arm & ~busy_q & ((inj_mode == 2'b01) | (inj_mode == 2'b10));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            dbl_q  <= 1'b0;
            lane_q <= '0;
            pos_q  <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= apply;
            if (apply) begin
                busy_q <= 1'b0;
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end else if (arm_ok) begin
                busy_q <= 1'b1;
                dbl_q  <= inj_mode[1];
                lane_q <= inj_lane;
                pos_q  <= (int'(inj_pos) < CW) ? inj_pos : '0;
            end
        end
    end

    // Second flipped bit wraps from CW-1 back to bit 0.
    always_comb begin
        flip = '0;
        for (int b = 0; b < CW; b++) begin
            if ((int'(pos_q) == b) ||
                (dbl_q && (int'(pos_q) == ((b == 0) ? CW - 1 : b - 1))))
                flip[b] = 1'b1;
        end
    end

    always_comb begin
        stage_in = enc_data;
        for (int k = 0; k < LANES; k++) begin
            if (apply && (int'(lane_q) == k))
                stage_in[k*CW +: CW] = enc_data[k*CW +: CW] ^ flip;
        end
    end

    assign inj_busy = busy_q;
    assign inj_done = done_q;
    assign inj_cnt  = cnt_q;
`else
    logic unused_inj;
    assign unused_inj = ^{inj_arm, inj_mode, inj_lane, inj_pos};
    assign stage_in   = enc_data;
    assign inj_busy   = 1'b0;
    assign inj_done   = 1'b0;
    assign inj_cnt    = 16'h0000;
`endif

    logic                v1;
    logic [LANES*CW-1:0] d1;
    logic                ld1;

    assign s_ready = ld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (ld1) begin
            v1 <= s_valid;
            if (s_valid) d1 <= stage_in;
        end
    end

    generate
        if (STAGES == 2) begin : g_two
            logic                v2;
            logic [LANES*CW-1:0] d2;
            logic                ld2;

            assign ld2 = ~v2 | m_ready;
            assign ld1 = ~v1 | ld2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else if (ld2) begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end

            assign m_valid = v2;
            assign m_data  = d2;
        end else begin : g_one
            assign ld1     = ~v1 | m_ready;
            assign m_valid = v1;
            assign m_data  = d1;
        end
    endgenerate

endmodule
